// File: rtl/risc16_decode_issue.sv
// RiSC-16 decode/operand-issue stage: register file, pending-write scoreboard, registered ALU operands.
// Optional define RISC16_WB_BYPASS_EN forwards same-cycle writeback data into operand reads.
module risc16_decode_issue #(
    parameter int NREGS = 8,
    parameter int XLEN  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_src1,
    output logic [XLEN-1:0] alu_src2,
    output logic            ADD,
    output logic            NAND,
    output logic            PASS1,
    output logic            EQ,
    output logic [2:0]      out_dest,
    output logic            out_we,
    output logic            out_mem_rd,
    output logic            out_mem_wr,
    output logic            out_br,
    output logic [XLEN-1:0] out_store_data,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_pc,
    input  logic            wb_en,
    input  logic [2:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data
);
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_ADDI = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_LUI  = 3'd3;
    localparam logic [2:0] OP_SW   = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_BEQ  = 3'd6;
    localparam logic [2:0] OP_JALR = 3'd7;

    typedef struct packed {
        logic [XLEN-1:0] src1;
        logic [XLEN-1:0] src2;
        logic            sel_add;
        logic            sel_nand;
        logic            sel_pass1;
        logic            sel_eq;
        logic [2:0]      dest;
        logic            we;
        logic            mem_rd;
        logic            mem_wr;
        logic            br;
        logic [XLEN-1:0] store_data;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [XLEN-1:0]  rf_q [NREGS];
    logic [XLEN-1:0]  rf_d [NREGS];
    logic [NREGS-1:0] pending_q, pending_d;
    entry_t           ent_q, ent_d, dec;
    logic             out_valid_q, out_valid_d;

    logic [2:0]      ra, rb, rc;
    logic [XLEN-1:0] imm7_sext, rd_a, rd_b, rd_c;
    logic            byp_a, byp_b, byp_c;
    logic            use_a, use_b, use_c, writes;
    logic            hazard, accept;

    assign ra        = in_instr[12:10];
    assign rb        = in_instr[9:7];
    assign rc        = in_instr[2:0];
    assign imm7_sext = {{(XLEN-7){in_instr[6]}}, in_instr[6:0]};

`ifdef RISC16_WB_BYPASS_EN
    assign byp_a = wb_en && (wb_addr == ra) && (ra != 3'd0);
    assign byp_b = wb_en && (wb_addr == rb) && (rb != 3'd0);
    assign byp_c = wb_en && (wb_addr == rc) && (rc != 3'd0);
`else
    assign byp_a = 1'b0;
    assign byp_b = 1'b0;
    assign byp_c = 1'b0;
`endif

    // r0 never holds a write, but keep the read explicit so a bypass can never leak into it
    assign rd_a = (ra == 3'd0) ? '0 : (byp_a ? wb_data : rf_q[ra]);
    assign rd_b = (rb == 3'd0) ? '0 : (byp_b ? wb_data : rf_q[rb]);
    assign rd_c = (rc == 3'd0) ? '0 : (byp_c ? wb_data : rf_q[rc]);

    always_comb begin
        dec    = '0;
        use_a  = 1'b0;
        use_b  = 1'b0;
        use_c  = 1'b0;
        writes = 1'b0;
        dec.pc = in_pc;
        case (in_instr[15:13])
            OP_ADD: begin
                use_b = 1'b1; use_c = 1'b1; writes = 1'b1;
                dec.src1 = rd_b; dec.src2 = rd_c; dec.sel_add = 1'b1;
            end
            OP_ADDI: begin
                use_b = 1'b1; writes = 1'b1;
                dec.src1 = rd_b; dec.src2 = imm7_sext; dec.sel_add = 1'b1;
            end
            OP_NAND: begin
                use_b = 1'b1; use_c = 1'b1; writes = 1'b1;
                dec.src1 = rd_b; dec.src2 = rd_c; dec.sel_nand = 1'b1;
            end
            OP_LUI: begin
                writes = 1'b1;
                dec.src1 = {in_instr[9:0], 6'b0}; dec.sel_pass1 = 1'b1;
            end
            OP_SW: begin
                use_a = 1'b1; use_b = 1'b1;
                dec.src1 = rd_b; dec.src2 = imm7_sext; dec.sel_add = 1'b1;
                dec.store_data = rd_a; dec.mem_wr = 1'b1;
            end
            OP_LW: begin
                use_b = 1'b1; writes = 1'b1;
                dec.src1 = rd_b; dec.src2 = imm7_sext; dec.sel_add = 1'b1;
                dec.mem_rd = 1'b1;
            end
            OP_BEQ: begin
                use_a = 1'b1; use_b = 1'b1;
                dec.src1 = rd_a; dec.src2 = rd_b; dec.sel_eq = 1'b1;
                dec.br = 1'b1; dec.imm = imm7_sext;
            end
            OP_JALR: begin
                use_b = 1'b1; writes = 1'b1;
                dec.src1 = rd_b; dec.sel_pass1 = 1'b1;
            end
        endcase
        dec.dest = writes ? ra : 3'd0;
        dec.we   = writes && (ra != 3'd0);
    end

    // A source being retired this cycle only clears its hazard when it is also bypassed
    always_comb begin
        hazard = (use_a && pending_q[ra] && !byp_a) ||
                 (use_b && pending_q[rb] && !byp_b) ||
                 (use_c && pending_q[rc] && !byp_c) ||
                 (dec.we && pending_q[ra]);
    end

    assign in_ready = !rst && !flush && !hazard && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        pending_d = pending_q;
        if (flush && out_valid_q && ent_q.we) pending_d[ent_q.dest] = 1'b0;
        if (wb_en) pending_d[wb_addr] = 1'b0;
        if (accept && dec.we) pending_d[ra] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_en && (wb_addr != 3'd0)) rf_d[wb_addr] = wb_data;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        ent_d       = ent_q;
        if (accept) begin
            out_valid_d = 1'b1;
            ent_d       = dec;
        end else if (flush || out_ready) begin
            out_valid_d     = 1'b0;
            ent_d.sel_add   = 1'b0;
            ent_d.sel_nand  = 1'b0;
            ent_d.sel_pass1 = 1'b0;
            ent_d.sel_eq    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            ent_q       <= '0;
            pending_q   <= '0;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            ent_q       <= ent_d;
            pending_q   <= pending_d;
            for (int i = 0; i < NREGS; i++) rf_q[i] <= rf_d[i];
        end
    end

    assign out_valid      = out_valid_q;
    assign alu_src1       = ent_q.src1;
    assign alu_src2       = ent_q.src2;
    assign ADD            = ent_q.sel_add;
    assign NAND           = ent_q.sel_nand;
    assign PASS1          = ent_q.sel_pass1;
    assign EQ             = ent_q.sel_eq;
    assign out_dest       = ent_q.dest;
    assign out_we         = ent_q.we;
    assign out_mem_rd     = ent_q.mem_rd;
    assign out_mem_wr     = ent_q.mem_wr;
    assign out_br         = ent_q.br;
    assign out_store_data = ent_q.store_data;
    assign out_imm        = ent_q.imm;
    assign out_pc         = ent_q.pc;
endmodule

// File: tb/tb_risc16_decode_issue.sv
// Scoreboard bench for risc16_decode_issue: directed instructions push expected entries, a monitor pops on handshake.
module tb_risc16_decode_issue;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [15:0] in_instr, in_pc, alu_src1, alu_src2, out_store_data, out_imm, out_pc;
    logic        ADD, NAND, PASS1, EQ, out_we, out_mem_rd, out_mem_wr, out_br;
    logic [2:0]  out_dest;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;

    int checks = 0;
    int errors = 0;
    logic [90:0] exp_q[$];

    localparam logic [3:0] S_ADD = 4'b1000, S_NAND = 4'b0100, S_PASS = 4'b0010, S_EQ = 4'b0001;

    risc16_decode_issue dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_pc(in_pc), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .ADD(ADD), .NAND(NAND), .PASS1(PASS1), .EQ(EQ),
        .out_dest(out_dest), .out_we(out_we), .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr),
        .out_br(out_br), .out_store_data(out_store_data), .out_imm(out_imm), .out_pc(out_pc),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    function automatic logic [90:0] mk(input logic [15:0] s1, input logic [15:0] s2,
                                       input logic [3:0] sel, input logic [2:0] dest,
                                       input logic we, input logic rd, input logic wr, input logic br,
                                       input logic [15:0] st, input logic [15:0] imm, input logic [15:0] pc);
        return {s1, s2, sel, dest, we, rd, wr, br, st, imm, pc};
    endfunction

    function automatic logic [90:0] act_vec();
        return {alu_src1, alu_src2, ADD, NAND, PASS1, EQ, out_dest, out_we,
                out_mem_rd, out_mem_wr, out_br, out_store_data, out_imm, out_pc};
    endfunction

    task automatic chk(input string name, input logic [90:0] act, input logic [90:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [2:0] a, input logic [15:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 1'b0;
    endtask

    task automatic issue(input logic [15:0] ins, input logic [15:0] pc, input logic [90:0] e,
                         input bit push, input int max_wait);
        int n = 0;
        in_valid = 1'b1; in_instr = ins; in_pc = pc;
        #1;
        while (!in_ready && n < max_wait) begin
            tick();
            n++;
        end
        chk($sformatf("issue_ready_pc%h", pc), 91'(in_ready), 91'(1));
        if (in_ready && push) exp_q.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    // Monitor: every handshaken, non-flushed entry must match the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !flush) begin
            chk("queue_nonempty", 91'(exp_q.size() != 0), 91'(1));
            if (exp_q.size() != 0) chk($sformatf("entry_pc%h", out_pc), act_vec(), exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
        out_ready = 1'b1; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        tick(); tick();
        chk("reset_valid", 91'(out_valid), 91'(0));
        chk("reset_outputs", act_vec(), 91'(0));
        chk("reset_in_ready", 91'(in_ready), 91'(0));
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 91'(in_ready), 91'(1));

        wb(3'd1, 16'h0005);
        wb(3'd2, 16'h0003);
        // ADD r3,r1,r2
        issue(16'h0C82, 16'h0010, mk(16'h0005, 16'h0003, S_ADD, 3'd3, 1, 0, 0, 0, 0, 0, 16'h0010), 1, 0);
        // LUI r4,0x3FF
        issue(16'h73FF, 16'h0011, mk(16'hFFC0, 16'h0000, S_PASS, 3'd4, 1, 0, 0, 0, 0, 0, 16'h0011), 1, 0);

        // ADDI r5,r4,-1 stalls on r4 until its writeback
        in_valid = 1'b1; in_instr = 16'h367F; in_pc = 16'h0012;
        #1;
        chk("raw_stall0", 91'(in_ready), 91'(0));
        tick();
        chk("raw_stall1", 91'(in_ready), 91'(0));
        wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'h1234;
        #1;
`ifdef RISC16_WB_BYPASS_EN
        chk("bypass_ready", 91'(in_ready), 91'(1));
        exp_q.push_back(mk(16'h1234, 16'hFFFF, S_ADD, 3'd5, 1, 0, 0, 0, 0, 0, 16'h0012));
        tick();
        wb_en = 1'b0; in_valid = 1'b0;
`else
        chk("wb_cycle_still_stalled", 91'(in_ready), 91'(0));
        tick();
        wb_en = 1'b0;
        #1;
        chk("ready_after_wb", 91'(in_ready), 91'(1));
        exp_q.push_back(mk(16'h1234, 16'hFFFF, S_ADD, 3'd5, 1, 0, 0, 0, 0, 0, 16'h0012));
        tick();
        in_valid = 1'b0;
`endif

        // BEQ r1,r1,-2 sets no pending bit, so NAND r0,r1,r1 issues at once
        issue(16'hC4FE, 16'h0013, mk(16'h0005, 16'h0005, S_EQ, 3'd0, 0, 0, 0, 1, 0, 16'hFFFE, 16'h0013), 1, 0);
        issue(16'h4081, 16'h0014, mk(16'h0005, 16'h0005, S_NAND, 3'd0, 0, 0, 0, 0, 0, 0, 16'h0014), 1, 0);
        tick();

        // SW r2,r1,3 held by back-pressure, JALR r7,r1 waiting behind it
        out_ready = 1'b0;
        issue(16'h8883, 16'h0020, mk(16'h0005, 16'h0003, S_ADD, 3'd0, 0, 0, 1, 0, 16'h0003, 0, 16'h0020), 1, 2);
        in_valid = 1'b1; in_instr = 16'hFC80; in_pc = 16'h0021;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("hold_ready%0d", i), 91'(in_ready), 91'(0));
            chk($sformatf("hold_valid%0d", i), 91'(out_valid), 91'(1));
            chk($sformatf("hold_out%0d", i), act_vec(),
                mk(16'h0005, 16'h0003, S_ADD, 3'd0, 0, 0, 1, 0, 16'h0003, 0, 16'h0020));
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("release_ready", 91'(in_ready), 91'(1));
        exp_q.push_back(mk(16'h0005, 16'h0000, S_PASS, 3'd7, 1, 0, 0, 0, 0, 0, 16'h0021));
        tick();
        in_valid = 1'b0;
        tick();
        wb(3'd7, 16'h0777);

        // ADD r6,r1,r2 killed by flush; its pending bit must clear without a writeback
        issue(16'h1882, 16'h0030, '0, 0, 0);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", 91'(in_ready), 91'(0));
        tick();
        flush = 1'b0;
        chk("flush_valid", 91'(out_valid), 91'(0));
        chk("flush_selects", 91'({ADD, NAND, PASS1, EQ}), 91'(0));
        issue(16'h1F06, 16'h0031, '0, 0, 0);
        out_ready = 1'b0;
        chk("add_r7_valid", 91'(out_valid), 91'(1));
        chk("add_r7_out", act_vec(), mk(16'h0000, 16'h0000, S_ADD, 3'd7, 1, 0, 0, 0, 0, 0, 16'h0031));

        // NAND r6,r7,r7 stalls on r7; asynchronous reset lands mid-stall
        in_valid = 1'b1; in_instr = 16'h5B87; in_pc = 16'h0040;
        #1;
        chk("stall_before_reset0", 91'(in_ready), 91'(0));
        tick();
        chk("stall_before_reset1", 91'(in_ready), 91'(0));
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_valid", 91'(out_valid), 91'(0));
        chk("async_reset_outputs", act_vec(), 91'(0));
        chk("async_reset_in_ready", 91'(in_ready), 91'(0));
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("pending_cleared_by_reset", 91'(in_ready), 91'(1));
        exp_q.push_back(mk(16'h0000, 16'h0000, S_NAND, 3'd6, 1, 0, 0, 0, 0, 0, 16'h0040));
        tick();
        in_valid = 1'b0;

        // r0 is never a destination and always reads as zero
        wb(3'd1, 16'h0009);
        wb(3'd2, 16'h0004);
        issue(16'h0082, 16'h0050, mk(16'h0009, 16'h0004, S_ADD, 3'd0, 0, 0, 0, 0, 0, 0, 16'h0050), 1, 0);
        wb_en = 1'b1; wb_addr = 3'd0; wb_data = 16'hBEEF;
        issue(16'h0400, 16'h0051, mk(16'h0000, 16'h0000, S_ADD, 3'd1, 1, 0, 0, 0, 0, 0, 16'h0051), 1, 0);
        wb_en = 1'b0;
        issue(16'h0800, 16'h0052, mk(16'h0000, 16'h0000, S_ADD, 3'd2, 1, 0, 0, 0, 0, 0, 16'h0052), 1, 0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        tick();
        chk("queue_drained", 91'(exp_q.size()), 91'(0));
        chk("idle_selects", 91'({ADD, NAND, PASS1, EQ}), 91'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
